// File: rtl/mux_rr_scheduler.sv
// Round-robin scheduler for the shared 3-input datapath mux: drives the mux select,
// holds grants for bursts of up to BURST beats and registers the muxed beat into a
// one-entry valid/ready output stage.
module mux_rr_scheduler #(
  parameter int WIDTH = 2,
  parameter int BURST = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       req,
  input  logic [WIDTH-1:0] I1,
  input  logic [WIDTH-1:0] I2,
  input  logic [WIDTH-1:0] I3,
  output logic [2:0]       ack,
  output logic [1:0]       sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       out_src
);

  localparam int CW = $clog2(BURST + 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t           state;
  logic [1:0]       ptr;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    cnt_nx;
  logic [1:0]       pick;
  logic             found;
  logic             xfer;
  logic [WIDTH-1:0] mux_data;

  always_comb begin
    case (sel)
      2'b00:   mux_data = I1;
      2'b01:   mux_data = I2;
      default: mux_data = I3;
    endcase
  end

  // First requester at or after the pointer, wrapping 0->1->2->0.
  always_comb begin
    found = 1'b0;
    pick  = ptr;
    for (int unsigned i = 0; i < 3; i++) begin
      int unsigned k;
      k = (32'(ptr) + i) % 3;
      if (!found && req[2'(k)]) begin
        found = 1'b1;
        pick  = 2'(k);
      end
    end
  end

  assign xfer   = (state == GRANT) && req[sel] && (!out_valid || out_ready);
  assign cnt_nx = cnt + 1'b1;
  assign ack    = (xfer && !rst) ? (3'b001 << sel) : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= '0;
      cnt       <= '0;
      sel       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= '0;
    end else begin
      if (xfer) begin
        out_data  <= mux_data;
        out_src   <= sel;
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (found) begin
            sel   <= pick;
            state <= GRANT;
          end
        end
        GRANT: begin
          if (xfer) cnt <= cnt_nx;
          // Release overrides the increment so the next grant starts from zero.
          if ((xfer && cnt_nx == CW'(BURST)) || !req[sel]) begin
            ptr   <= (sel == 2'd2) ? 2'd0 : sel + 2'd1;
            cnt   <= '0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mux_rr_scheduler.sv
// Randomized bench for mux_rr_scheduler: two instances (BURST=4 and BURST=1) share
// stimulus and are compared each cycle against a behavioural model of the rules.
module tb_mux_rr_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] req;
  logic [1:0] I1, I2, I3;
  logic       out_ready;

  logic [2:0] ack_a, ack_b;
  logic [1:0] sel_a, sel_b, data_a, data_b, src_a, src_b;
  logic       ov_a, ov_b;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mux_rr_scheduler #(.WIDTH(2), .BURST(4)) dut_a (
    .clk(clk), .rst(rst), .req(req), .I1(I1), .I2(I2), .I3(I3),
    .ack(ack_a), .sel(sel_a), .out_valid(ov_a), .out_ready(out_ready),
    .out_data(data_a), .out_src(src_a)
  );

  mux_rr_scheduler #(.WIDTH(2), .BURST(1)) dut_b (
    .clk(clk), .rst(rst), .req(req), .I1(I1), .I2(I2), .I3(I3),
    .ack(ack_b), .sel(sel_b), .out_valid(ov_b), .out_ready(out_ready),
    .out_data(data_b), .out_src(src_b)
  );

  // Model state per instance; granted requester -1 means nobody holds the mux.
  int burst[2] = '{4, 1};
  int g[2], ptr[2], cnt[2], msel[2], mv[2], mdat[2], msrc[2];

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, obs, exp);
    end
  endtask

  function automatic int data_of(input int k);
    return (k == 0) ? int'(I1) : (k == 1) ? int'(I2) : int'(I3);
  endfunction

  function automatic bit takes(input int i);
    return g[i] >= 0 && req[g[i]] && (mv[i] == 0 || out_ready);
  endfunction

  function automatic int exp_ack(input int i);
    return (!rst && takes(i)) ? (1 << g[i]) : 0;
  endfunction

  task automatic model_reset(input int i);
    g[i] = -1; ptr[i] = 0; cnt[i] = 0; msel[i] = 0;
    mv[i] = 0; mdat[i] = 0; msrc[i] = 0;
  endtask

  task automatic model_edge(input int i);
    bit t;
    if (rst) begin
      model_reset(i);
      return;
    end
    t = takes(i);
    if (t) begin
      mdat[i] = data_of(g[i]); msrc[i] = g[i]; mv[i] = 1; cnt[i]++;
    end else if (out_ready) begin
      mv[i] = 0;
    end
    if (g[i] >= 0) begin
      if ((t && cnt[i] == burst[i]) || !req[g[i]]) begin
        ptr[i] = (g[i] + 1) % 3; cnt[i] = 0; g[i] = -1;
      end
    end else begin
      for (int j = 0; j < 3; j++) begin
        if (g[i] < 0 && req[(ptr[i] + j) % 3]) begin
          g[i] = (ptr[i] + j) % 3;
          msel[i] = g[i];
        end
      end
    end
  endtask

  task automatic step(input bit r, input logic [2:0] q, input bit rdy);
    @(negedge clk);
    rst = r; req = q; out_ready = rdy;
    I1 = 2'($urandom); I2 = 2'($urandom); I3 = 2'($urandom);
    #1;
    check("ack4", int'(ack_a), exp_ack(0));
    check("sel4", int'(sel_a), msel[0]);
    check("valid4", int'(ov_a), mv[0]);
    check("data4", int'(data_a), mdat[0]);
    check("src4", int'(src_a), msrc[0]);
    check("ack1", int'(ack_b), exp_ack(1));
    check("sel1", int'(sel_b), msel[1]);
    check("valid1", int'(ov_b), mv[1]);
    check("data1", int'(data_b), mdat[1]);
    check("src1", int'(src_b), msrc[1]);
    @(posedge clk);
    model_edge(0);
    model_edge(1);
  endtask

  initial begin
    logic [2:0] q;
    rst = 1'b1; req = 3'b111; out_ready = 1'b1;
    I1 = '0; I2 = '0; I3 = '0;
    @(posedge clk);
    model_reset(0);
    model_reset(1);

    repeat (2) step(1'b1, 3'b111, 1'b1);
    repeat (12) step(1'b0, 3'b010, 1'b1);
    repeat (16) step(1'b0, 3'b111, 1'b1);
    repeat (3) step(1'b0, 3'b111, 1'b0);
    repeat (4) step(1'b0, 3'b101, 1'b1);
    repeat (2) step(1'b0, 3'b100, 1'b1);

    q = 3'b111;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 3) == 0) q = 3'($urandom);
      step($urandom_range(0, 63) == 0, q, $urandom_range(0, 3) != 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
